// File: rtl/saus_unreverse_buffer_if.sv
// saus_unreverse_buffer_if
//   Handshake bundle for the SAUS un-reverse buffer.
//   Input stream : in_valid / in_ready / in_data[PAR] / in_last
//   Output vector: out_valid / out_ready / out_vector[32] / err_last
//   Modports: slave  = the buffer itself
//             master = whoever drives beats in and takes vectors out
interface saus_unreverse_buffer_if #(
    parameter int WIDTH = 16,
    parameter int PAR   = 4
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data [PAR-1:0];
    logic             in_last;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_vector [31:0];
    logic             err_last;

    modport slave (
        input  in_valid, in_data, in_last, out_ready,
        output in_ready, out_valid, out_vector, err_last
    );

    modport master (
        output in_valid, in_data, in_last, out_ready,
        input  in_ready, out_valid, out_vector, err_last
    );
endinterface

// File: rtl/saus_unreverse_buffer.sv
// saus_unreverse_buffer
//   Reassembles a stream of PAR-sample beats into 32-sample vectors, writing
//   them in segment-reversed order (segment order flipped, order inside a
//   segment kept). Two banks ping-pong so a new vector can fill while the
//   previous one is presented on out_vector.
//
//   Ports:
//     clk    rising-edge clock
//     rst_n  asynchronous active-low reset
//     bus    saus_unreverse_buffer_if.slave (input beats, output vectors,
//            sticky framing error)
//
//   Optional feature macro: SAUS_UNREV_LAST_CHECK_EN
//     Defined   : in_last is checked on every accepted beat; a mismatch sets
//                 err_last (sticky); an early in_last closes the vector.
//     Undefined : in_last is ignored, err_last is tied low.
module saus_unreverse_buffer #(
    parameter int WIDTH = 16,
    parameter int N     = 32,
    parameter int PAR   = 4
) (
    input logic                    clk,
    input logic                    rst_n,
    saus_unreverse_buffer_if.slave bus
);
    localparam int BEATS = 32 / PAR;
    localparam int CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
    // With N a power of two, the segment-reversed address 32-(p/N+1)*N+p%N
    // equals p with its segment-index bits inverted.
    localparam logic [4:0] SEG_MASK = 5'(~(N - 1));

    generate
        if ((N < 1) || (N > 32) || ((N & (N - 1)) != 0)) begin : g_bad_n
            $error("saus_unreverse_buffer: N must be a power of two dividing 32");
        end
        if ((PAR < 1) || (PAR > 32) || ((32 % PAR) != 0)) begin : g_bad_par
            $error("saus_unreverse_buffer: PAR must divide 32");
        end
    endgenerate

    typedef enum logic {S_EMPTY, S_SHOW} state_e;

    state_e             state_q;
    logic [CNT_W-1:0]   beat_cnt_q;
    logic               wr_bank_q;
    logic               rd_bank_q;
    logic [1:0]         full_q;
    logic [1:0]         full_d;
    logic               out_valid_q;
    logic [WIDTH-1:0]   vec_q  [31:0];
    logic [WIDTH-1:0]   bank_q [2][32];
    logic [4:0]         waddr  [PAR];

    logic in_ready;
    logic acc;
    logic last_beat;
    logic complete;
    logic rd_clr;

    assign in_ready  = !full_q[wr_bank_q];
    assign acc       = bus.in_valid && in_ready;
    assign last_beat = (beat_cnt_q == CNT_W'(BEATS - 1));
    assign rd_clr    = (state_q == S_SHOW) && bus.out_ready;

`ifdef SAUS_UNREV_LAST_CHECK_EN
    // An early in_last closes the vector; unwritten slots keep stale data.
    assign complete = acc && (last_beat || bus.in_last);
`else
    logic unused_in_last;
    assign unused_in_last = bus.in_last;
    assign complete = acc && last_beat;
`endif

    for (genvar l = 0; l < PAR; l++) begin : g_lane
        logic [4:0] pos;
        assign pos      = 5'(beat_cnt_q) * 5'(PAR) + 5'(l);
        assign waddr[l] = pos ^ SEG_MASK;
    end

    // Sample storage needs no reset; only flags and outputs are cleared.
    always_ff @(posedge clk) begin
        if (acc) begin
            for (int l = 0; l < PAR; l++) begin
                bank_q[wr_bank_q][waddr[l]] <= bus.in_data[l];
            end
        end
    end

    // Write-side set and read-side clear always target different banks.
    always_comb begin
        full_d = full_q;
        if (rd_clr)   full_d[rd_bank_q] = 1'b0;
        if (complete) full_d[wr_bank_q] = 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_EMPTY;
            beat_cnt_q  <= '0;
            wr_bank_q   <= 1'b0;
            rd_bank_q   <= 1'b0;
            full_q      <= '0;
            out_valid_q <= 1'b0;
            for (int i = 0; i < 32; i++) vec_q[i] <= '0;
        end else begin
            full_q <= full_d;
            if (acc) beat_cnt_q <= complete ? '0 : beat_cnt_q + CNT_W'(1);
            if (complete) wr_bank_q <= ~wr_bank_q;

            case (state_q)
                S_EMPTY: begin
                    if (full_q[rd_bank_q]) begin
                        for (int i = 0; i < 32; i++) vec_q[i] <= bank_q[rd_bank_q][i];
                        out_valid_q <= 1'b1;
                        state_q     <= S_SHOW;
                    end
                end
                S_SHOW: begin
                    if (bus.out_ready) begin
                        rd_bank_q <= ~rd_bank_q;
                        // Other bank already waiting: swap it in with no bubble.
                        if (full_q[~rd_bank_q]) begin
                            for (int i = 0; i < 32; i++) vec_q[i] <= bank_q[~rd_bank_q][i];
                        end else begin
                            out_valid_q <= 1'b0;
                            state_q     <= S_EMPTY;
                        end
                    end
                end
                default: state_q <= S_EMPTY;
            endcase
        end
    end

`ifdef SAUS_UNREV_LAST_CHECK_EN
    logic err_q;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                                 err_q <= 1'b0;
        else if (acc && (bus.in_last != last_beat)) err_q <= 1'b1;
    end
    assign bus.err_last = err_q;
`else
    assign bus.err_last = 1'b0;
`endif

    assign bus.in_ready  = in_ready;
    assign bus.out_valid = out_valid_q;
    for (genvar i = 0; i < 32; i++) begin : g_out
        assign bus.out_vector[i] = vec_q[i];
    end
endmodule

// File: tb/tb_saus_unreverse_buffer.sv
// Bench for saus_unreverse_buffer: three instances (N=8, N=32, N=1) share one
// input stream; a queue-level model predicts in_ready, out_valid, err_last
// and the expected reassembled vectors.
module tb_saus_unreverse_buffer;
    localparam int W     = 16;
    localparam int PAR   = 4;
    localparam int BEATS = 32 / PAR;
    localparam int ND    = 3;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic         iv, il, ordy;
    logic [W-1:0] din [PAR];

    saus_unreverse_buffer_if #(.WIDTH(W), .PAR(PAR)) if0 ();
    saus_unreverse_buffer_if #(.WIDTH(W), .PAR(PAR)) if1 ();
    saus_unreverse_buffer_if #(.WIDTH(W), .PAR(PAR)) if2 ();

    saus_unreverse_buffer #(.WIDTH(W), .N(8),  .PAR(PAR)) dut0 (.clk(clk), .rst_n(rst_n), .bus(if0));
    saus_unreverse_buffer #(.WIDTH(W), .N(32), .PAR(PAR)) dut1 (.clk(clk), .rst_n(rst_n), .bus(if1));
    saus_unreverse_buffer #(.WIDTH(W), .N(1),  .PAR(PAR)) dut2 (.clk(clk), .rst_n(rst_n), .bus(if2));

    assign if0.in_valid = iv;   assign if1.in_valid = iv;   assign if2.in_valid = iv;
    assign if0.in_last  = il;   assign if1.in_last  = il;   assign if2.in_last  = il;
    assign if0.out_ready = ordy; assign if1.out_ready = ordy; assign if2.out_ready = ordy;
    for (genvar l = 0; l < PAR; l++) begin : g_drv
        assign if0.in_data[l] = din[l];
        assign if1.in_data[l] = din[l];
        assign if2.in_data[l] = din[l];
    end

    // ---------------- reference model ----------------
    int           mbeat;
    int           q[$];          // slots of completed, unconsumed vectors
    bit           shown;         // front of q is on out_vector
    int           serial;
    bit           merr;
    logic [W-1:0] cur_s [32];
    bit           cur_w [32];
    logic [W-1:0] hs_s [4][32];
    bit           hs_w [4][32];

    int n_cmp, n_bad;
    int n_dacc;                  // beats the DUT accepted (observed)

    function automatic int nof(int d);
        return (d == 0) ? 8 : ((d == 1) ? 32 : 1);
    endfunction

    function automatic bit lastv();
`ifdef SAUS_UNREV_LAST_CHECK_EN
        return (mbeat == BEATS - 1);
`else
        return bit'($urandom_range(0, 1));
`endif
    endfunction

    task automatic model_reset();
        q.delete();
        shown = 0; mbeat = 0; merr = 0;
        for (int p = 0; p < 32; p++) cur_w[p] = 0;
    endtask

    task automatic model_edge();
        bit mrdy, acc, lastb, cmpl;
        int k;
        mrdy  = (q.size() < 2);
        acc   = iv && mrdy;
        lastb = (mbeat == BEATS - 1);
`ifdef SAUS_UNREV_LAST_CHECK_EN
        cmpl = acc && (lastb || il);
        if (acc && (il != lastb)) merr = 1;
`else
        cmpl = acc && lastb;
`endif
        if (acc) begin
            for (int l = 0; l < PAR; l++) begin
                cur_s[mbeat*PAR + l] = din[l];
                cur_w[mbeat*PAR + l] = 1;
            end
            mbeat = cmpl ? 0 : mbeat + 1;
        end
        if (shown && ordy) begin
            void'(q.pop_front());
            shown = (q.size() > 0);
        end else if (!shown) begin
            shown = (q.size() > 0);
        end
        if (cmpl) begin
            k = serial % 4;
            for (int p = 0; p < 32; p++) begin
                hs_s[k][p] = cur_s[p];
                hs_w[k][p] = cur_w[p];
                cur_w[p]   = 0;
            end
            q.push_back(k);
            serial++;
        end
    endtask

    // ---------------- checking ----------------
    task automatic chk(string name, int act, int exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic check(string tag);
        logic [W-1:0] dv [ND][32];
        logic         dvld [ND];
        logic         drdy [ND];
        logic         derr [ND];
        for (int i = 0; i < 32; i++) begin
            dv[0][i] = if0.out_vector[i];
            dv[1][i] = if1.out_vector[i];
            dv[2][i] = if2.out_vector[i];
        end
        dvld[0] = if0.out_valid; dvld[1] = if1.out_valid; dvld[2] = if2.out_valid;
        drdy[0] = if0.in_ready;  drdy[1] = if1.in_ready;  drdy[2] = if2.in_ready;
        derr[0] = if0.err_last;  derr[1] = if1.err_last;  derr[2] = if2.err_last;
        for (int d = 0; d < ND; d++) begin
            chk($sformatf("%s dut%0d in_ready", tag, d), int'(drdy[d]), int'(q.size() < 2));
            chk($sformatf("%s dut%0d out_valid", tag, d), int'(dvld[d]), int'(shown));
            chk($sformatf("%s dut%0d err_last", tag, d), int'(derr[d]), int'(merr));
            if (shown) begin
                int k, n, bad;
                logic [W-1:0] ev, av;
                k = q[0]; n = nof(d); bad = -1; ev = '0; av = '0;
                for (int p = 0; p < 32; p++) begin
                    int idx;
                    idx = 32 - (p / n + 1) * n + p % n;
                    if (hs_w[k][p] && (dv[d][idx] !== hs_s[k][p]) && (bad < 0)) begin
                        bad = idx; ev = hs_s[k][p]; av = dv[d][idx];
                    end
                end
                n_cmp++;
                if (bad >= 0) begin
                    n_bad++;
                    $display("FAIL %s dut%0d vector[%0d]: got %0h expected %0h", tag, d, bad, av, ev);
                end
            end
        end
    endtask

    // One cycle: drive at negedge, model at posedge, compare at next negedge.
    task automatic step(string tag, bit v, bit last, bit r);
        iv = v; il = last; ordy = r;
        #1;
        if (v && if0.in_ready) n_dacc++;
        @(posedge clk);
        model_edge();
        @(negedge clk);
        check(tag);
    endtask

    task automatic rnd_din();
        for (int l = 0; l < PAR; l++) din[l] = W'($urandom);
    endtask

    task automatic do_reset();
        rst_n = 1'b0; iv = 0; il = 0; ordy = 0;
        model_reset();
        @(negedge clk);
        chk("reset out_valid", int'(if0.out_valid), 0);
        chk("reset in_ready", int'(if0.in_ready), 1);
        chk("reset err_last", int'(if0.err_last), 0);
        begin
            int nz;
            nz = 0;
            for (int i = 0; i < 32; i++)
                if ((if0.out_vector[i] | if1.out_vector[i] | if2.out_vector[i]) !== '0) nz++;
            chk("reset out_vector nonzero count", nz, 0);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("post-reset");
    endtask

    initial begin
        int got, cyc;
        n_cmp = 0; n_bad = 0; n_dacc = 0; serial = 0;
        iv = 0; il = 0; ordy = 0;
        for (int l = 0; l < PAR; l++) din[l] = '0;
        do_reset();

        // Directed: sample value = stream position.
        for (int b = 0; b < BEATS; b++) begin
            for (int l = 0; l < PAR; l++) din[l] = W'(b*PAR + l);
            step("directed", 1, lastv(), 1);
        end
        chk("latency out_valid after last beat", int'(if0.out_valid), 0);
        step("directed idle", 0, 0, 1);
        chk("latency out_valid one cycle later", int'(if0.out_valid), 1);
        chk("N8 vec[0]",  int'(if0.out_vector[0]),  24);
        chk("N8 vec[7]",  int'(if0.out_vector[7]),  31);
        chk("N8 vec[8]",  int'(if0.out_vector[8]),  16);
        chk("N8 vec[31]", int'(if0.out_vector[31]), 7);
        chk("N32 vec[5]", int'(if1.out_vector[5]),  5);
        chk("N1 vec[31]", int'(if2.out_vector[31]), 0);
        chk("N1 vec[0]",  int'(if2.out_vector[0]),  31);
        for (int i = 0; i < 3; i++) step("directed drain", 0, 0, 1);

        // Backpressure: 24 beats offered with out_ready low.
        n_dacc = 0;
        for (int c = 0; c < 24; c++) begin
            rnd_din();
            if (c == 16) chk("bp in_ready low at offer 16", int'(if0.in_ready), 0);
            step("backpressure", 1, lastv(), 0);
        end
        chk("bp accepted beats", n_dacc, 16);
        n_dacc = 0; cyc = 0;
        while (n_dacc < 8 && cyc < 30) begin
            if (cyc < 2) chk($sformatf("bp drain out_valid c%0d", cyc), int'(if0.out_valid), 1);
            rnd_din();
            step("bp drain", 1, lastv(), 1);
            cyc++;
        end
        chk("bp remaining beats accepted", n_dacc, 8);
        for (int i = 0; i < 4; i++) step("bp idle", 0, 0, 1);

        // Continuous stream of four vectors.
        n_dacc = 0;
        for (int c = 0; c < 4*BEATS; c++) begin
            rnd_din();
            step("stream", 1, lastv(), 1);
        end
        chk("stream one beat per cycle", n_dacc, 4*BEATS);
        for (int i = 0; i < 4; i++) step("stream idle", 0, 0, 1);

        // Reset in the middle of a vector.
        for (int b = 0; b < 4; b++) begin
            rnd_din();
            step("pre-reset", 1, lastv(), 1);
        end
        do_reset();
        chk("mid-reset out_valid", int'(if0.out_valid), 0);
        chk("mid-reset in_ready", int'(if0.in_ready), 1);
        for (int b = 0; b < BEATS; b++) begin
            rnd_din();
            step("after reset", 1, lastv(), 1);
        end
        for (int i = 0; i < 3; i++) step("after reset idle", 0, 0, 1);

`ifdef SAUS_UNREV_LAST_CHECK_EN
        // Early in_last on beat 5 closes the vector after 6 beats.
        for (int b = 0; b < 6; b++) begin
            rnd_din();
            step("early last", 1, (b == 5), 1);
        end
        chk("early last err_last", int'(if0.err_last), 1);
        step("early last idle", 0, 0, 1);
        chk("early last vector shown", int'(if0.out_valid), 1);
        for (int b = 0; b < BEATS; b++) begin
            rnd_din();
            step("reframed", 1, lastv(), 1);
        end
        for (int i = 0; i < 3; i++) step("reframed idle", 0, 0, 1);
        chk("err_last sticky", int'(if0.err_last), 1);
`endif

        // Random traffic.
        for (int c = 0; c < 400; c++) begin
            rnd_din();
            step("random", ($urandom_range(0, 3) != 0), lastv(), ($urandom_range(0, 2) != 0));
        end
        got = 0;
        for (int i = 0; i < 20; i++) step("final drain", 0, 0, 1);
        chk("final queue empty", q.size(), got);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
